// File: rtl/bram18_pkg.sv
// Shared types and sizing for the BRAM18 true-dual-port responder:
// port-width mode encodings, lane-width table and array index widths.
package bram18_pkg;

  typedef enum logic [2:0] {
    MODE_1  = 3'b101,
    MODE_2  = 3'b110,
    MODE_4  = 3'b100,
    MODE_9  = 3'b001,
    MODE_18 = 3'b010
  } mode_e;

  localparam int unsigned DATA_W = 18;
  localparam int unsigned ROW_W  = 10;
  localparam int unsigned LANE_W = 4;
  localparam int unsigned DEPTH  = 1 << ROW_W;

  // 3'b011 (36/32) and every unlisted code collapse to the 18-bit mode
  function automatic mode_e norm_mode(input logic [2:0] m);
    case (m)
      3'b101:  return MODE_1;
      3'b110:  return MODE_2;
      3'b100:  return MODE_4;
      3'b001:  return MODE_9;
      default: return MODE_18;
    endcase
  endfunction

  function automatic int unsigned lane_width(input mode_e m);
    case (m)
      MODE_1:  return 1;
      MODE_2:  return 2;
      MODE_4:  return 4;
      MODE_9:  return 9;
      default: return 18;
    endcase
  endfunction

endpackage

// File: rtl/bram18_lane_decode.sv
// Maps the port mode and the low effective-address bits to the row bits
// occupied by the addressed lane and the bit offset of that lane.
module bram18_lane_decode
  import bram18_pkg::*;
(
  input  mode_e             mode_i,
  input  logic [LANE_W-1:0] lane_i,
  output logic [DATA_W-1:0] mask_o,
  output logic [4:0]        shift_o
);

  always_comb begin
    shift_o = '0;
    mask_o  = '1;
    case (mode_i)
      MODE_9: begin
        // byte lane plus its parity bit in the top two row bits
        shift_o = 5'({lane_i[3], 3'b000});
        mask_o  = (18'h000FF << shift_o) | (18'h10000 << lane_i[3]);
      end
      MODE_4: begin
        shift_o = 5'({lane_i[3:2], 2'b00});
        mask_o  = 18'h0000F << shift_o;
      end
      MODE_2: begin
        shift_o = 5'({lane_i[3:1], 1'b0});
        mask_o  = 18'h00003 << shift_o;
      end
      MODE_1: begin
        shift_o = 5'(lane_i);
        mask_o  = 18'h00001 << shift_o;
      end
      default: begin
        shift_o = '0;
        mask_o  = '1;
      end
    endcase
  end

endmodule

// File: rtl/bram18_tdp_responder.sv
// 1024x18 true-dual-port block RAM model, read-first, port A wins collisions.
// Optional COLLISION_o pulse enabled by defining BRAM18_TDP_COLLISION_EN.
module bram18_tdp_responder
  import bram18_pkg::*;
#(
  parameter logic [2:0]              MODE = 3'b010,
  parameter logic [DATA_W*DEPTH-1:0] INIT = '0
) (
  input  logic        CLK_i,
  input  logic        RESET_ni,
  input  logic [14:0] ADDR_A_i,
  input  logic [14:0] ADDR_B_i,
  input  logic        REN_A_i,
  input  logic        REN_B_i,
  input  logic        WEN_A_i,
  input  logic        WEN_B_i,
  input  logic [1:0]  BE_A_i,
  input  logic [1:0]  BE_B_i,
  input  logic [17:0] WDATA_A_i,
  input  logic [17:0] WDATA_B_i,
  output logic [17:0] RDATA_A_o,
  output logic [17:0] RDATA_B_o,
  input  logic        FLUSH_i
`ifdef BRAM18_TDP_COLLISION_EN
  ,
  output logic        COLLISION_o
`endif
);

  localparam mode_e             MODE_N      = norm_mode(MODE);
  localparam logic [DATA_W-1:0] NARROW_MASK = DATA_W'((1 << lane_width(MODE_N)) - 1);

  logic [DATA_W*DEPTH-1:0] mem_q = INIT;
  logic [DATA_W-1:0]       rdata_q [2];

  logic [13:0]       eff   [2];
  logic [ROW_W-1:0]  row   [2];
  logic [1:0]        be    [2];
  logic [DATA_W-1:0] wdata [2];
  logic [DATA_W-1:0] lmask [2];
  logic [4:0]        shift [2];
  logic              ren   [2];
  logic              wen   [2];
  logic              we    [2];
  logic [DATA_W-1:0] old   [2];
  logic [DATA_W-1:0] wmask [2];
  logic [DATA_W-1:0] waln  [2];
  logic [DATA_W-1:0] rd_d  [2];
  logic [DATA_W-1:0] new_d [2];
  logic [DATA_W-1:0] merged_d;
  logic              same_row;
  logic              unused_addr_lsb;

  assign eff[0]   = ADDR_A_i[14:1];
  assign eff[1]   = ADDR_B_i[14:1];
  assign be[0]    = BE_A_i;
  assign be[1]    = BE_B_i;
  assign wdata[0] = WDATA_A_i;
  assign wdata[1] = WDATA_B_i;
  assign ren[0]   = REN_A_i;
  assign ren[1]   = REN_B_i;
  assign wen[0]   = WEN_A_i;
  assign wen[1]   = WEN_B_i;
  assign unused_addr_lsb = ADDR_A_i[0] ^ ADDR_B_i[0];

  for (genvar p = 0; p < 2; p++) begin : g_port
    assign row[p] = eff[p][13:4];
    assign we[p]  = wen[p] & RESET_ni;
    bram18_lane_decode u_lane (
      .mode_i (MODE_N),
      .lane_i (eff[p][3:0]),
      .mask_o (lmask[p]),
      .shift_o(shift[p])
    );
  end

  function automatic logic [14:0] row_base(input logic [ROW_W-1:0] r);
    return 15'(r) * 15'd18;
  endfunction

  assign same_row = (row[0] == row[1]);

  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      old[p]   = mem_q[row_base(row[p]) +: DATA_W];
      wmask[p] = (MODE_N == MODE_18) ?
                 {be[p][1], be[p][0], {8{be[p][1]}}, {8{be[p][0]}}} : lmask[p];
      waln[p]  = wdata[p] << shift[p];
      rd_d[p]  = (old[p] >> shift[p]) & NARROW_MASK;
      if (MODE_N == MODE_9) begin
        waln[p] = 18'(wdata[p][7:0]) << shift[p];
        waln[p][5'd16 + 5'(eff[p][3])] = wdata[p][16];
        rd_d[p] = '0;
        rd_d[p][7:0] = 8'(old[p] >> shift[p]);
        rd_d[p][16]  = old[p][5'd16 + 5'(eff[p][3])];
      end else if (MODE_N == MODE_18) begin
        rd_d[p] = old[p];
      end
      new_d[p] = (old[p] & ~wmask[p]) | (waln[p] & wmask[p]);
    end
    // both ports on one row: fold B's bits in under A so a single write carries both
    merged_d = (new_d[1] & ~wmask[0]) | (waln[0] & wmask[0]);
  end

  always_ff @(posedge CLK_i) begin
    if (we[1] && !(we[0] && same_row))
      mem_q[row_base(row[1]) +: DATA_W] <= new_d[1];
    if (we[0])
      mem_q[row_base(row[0]) +: DATA_W] <= (we[1] && same_row) ? merged_d : new_d[0];
  end

  always_ff @(posedge CLK_i) begin
    for (int unsigned p = 0; p < 2; p++) begin
      if (!RESET_ni || FLUSH_i) rdata_q[p] <= '0;
      else if (ren[p])          rdata_q[p] <= rd_d[p];
    end
  end

  assign RDATA_A_o = rdata_q[0];
  assign RDATA_B_o = rdata_q[1];

`ifdef BRAM18_TDP_COLLISION_EN
  logic coll_q;
  always_ff @(posedge CLK_i) begin
    if (!RESET_ni) coll_q <= 1'b0;
    else           coll_q <= same_row && (ren[0] || wen[0]) && (ren[1] || wen[1])
                             && (wen[0] || wen[1]);
  end
  assign COLLISION_o = coll_q;
`endif

endmodule

// File: tb/tb_bram18_tdp_responder.sv
// Directed bench for bram18_tdp_responder in 18, 9 and 1 bit modes.
// Collision checks are compiled in when BRAM18_TDP_COLLISION_EN is defined.
module tb_bram18_tdp_responder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [14:0] addr_a [3];
  logic [14:0] addr_b [3];
  logic        ren_a  [3];
  logic        ren_b  [3];
  logic        wen_a  [3];
  logic        wen_b  [3];
  logic [1:0]  be_a   [3];
  logic [1:0]  be_b   [3];
  logic [17:0] wd_a   [3];
  logic [17:0] wd_b   [3];
  logic [17:0] rd_a   [3];
  logic [17:0] rd_b   [3];
  logic        flush  [3];
  logic        coll   [3];

  int n_checks = 0;
  int n_errors = 0;

  // index 0: 18-bit mode, 1: 9-bit mode, 2: 1-bit mode
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam logic [2:0] M = (g == 0) ? 3'b010 : (g == 1) ? 3'b001 : 3'b101;
    bram18_tdp_responder #(.MODE(M)) u_dut (
      .CLK_i      (clk),
      .RESET_ni   (rst_n),
      .ADDR_A_i   (addr_a[g]),
      .ADDR_B_i   (addr_b[g]),
      .REN_A_i    (ren_a[g]),
      .REN_B_i    (ren_b[g]),
      .WEN_A_i    (wen_a[g]),
      .WEN_B_i    (wen_b[g]),
      .BE_A_i     (be_a[g]),
      .BE_B_i     (be_b[g]),
      .WDATA_A_i  (wd_a[g]),
      .WDATA_B_i  (wd_b[g]),
      .RDATA_A_o  (rd_a[g]),
      .RDATA_B_o  (rd_b[g]),
      .FLUSH_i    (flush[g])
`ifdef BRAM18_TDP_COLLISION_EN
      ,
      .COLLISION_o(coll[g])
`endif
    );
`ifndef BRAM18_TDP_COLLISION_EN
    assign coll[g] = 1'b0;
`endif
  end

  task automatic check(input string tag, input logic [17:0] got, input logic [17:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%05h expected 0x%05h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    for (int d = 0; d < 3; d++) begin
      addr_a[d] = '0; addr_b[d] = '0; ren_a[d] = 0; ren_b[d] = 0;
      wen_a[d] = 0; wen_b[d] = 0; be_a[d] = '0; be_b[d] = '0;
      wd_a[d] = '0; wd_b[d] = '0; flush[d] = 0;
    end
  endtask

  task automatic set_a(input int d, input logic [14:0] a, input logic r, input logic w,
                       input logic [17:0] wd, input logic [1:0] be);
    addr_a[d] = a; ren_a[d] = r; wen_a[d] = w; wd_a[d] = wd; be_a[d] = be;
  endtask

  task automatic set_b(input int d, input logic [14:0] a, input logic r, input logic w,
                       input logic [17:0] wd, input logic [1:0] be);
    addr_b[d] = a; ren_b[d] = r; wen_b[d] = w; wd_b[d] = wd; be_b[d] = be;
  endtask

  initial begin
    clr();
    rst_n = 1'b0;
    tick(); tick();
    for (int d = 0; d < 3; d++) begin
      check("reset_rd_a", rd_a[d], 18'h0);
      check("reset_rd_b", rd_b[d], 18'h0);
    end
`ifdef BRAM18_TDP_COLLISION_EN
    check("reset_coll", 18'(coll[0]), 18'h0);
`endif
    rst_n = 1'b1;

    // 18 mode: full write on A, read on B with one-cycle latency and hold
    set_a(0, 15'h0000, 0, 1, 18'h2ABCD, 2'b11); tick(); clr();
    set_b(0, 15'h0000, 1, 0, 18'h0, 2'b00);
    check("lat_before_edge", rd_b[0], 18'h0);
    tick(); clr();
    check("rd18_b", rd_b[0], 18'h2ABCD);
    tick();
    check("rd18_hold", rd_b[0], 18'h2ABCD);

    // 18 mode byte enable: BE=01 over zero; address bit 0 ignored on readback
    set_a(0, 15'h0000, 0, 1, 18'h00000, 2'b11); tick(); clr();
    set_a(0, 15'h0000, 0, 1, 18'h3FFFF, 2'b01); tick(); clr();
    set_a(0, 15'h0001, 1, 0, 18'h0, 2'b00); tick(); clr();
    check("be01", rd_a[0], 18'h100FF);

    // 9 mode: lane 0 then lane 1 of row 0, parity carried on bit 16
    set_a(1, 15'h0000, 0, 1, 18'h1005A, 2'b00); tick(); clr();
    set_a(1, 15'h0010, 0, 1, 18'h100A5, 2'b00); tick(); clr();
    set_a(1, 15'h0010, 1, 0, 18'h0, 2'b00);
    set_b(1, 15'h0000, 1, 0, 18'h0, 2'b00); tick(); clr();
    check("rd9_eff8", rd_a[1], 18'h100A5);
    check("rd9_eff0", rd_b[1], 18'h1005A);

    // 1 mode: single bit at eff 13, neighbours stay clear
    set_a(2, 15'h001A, 0, 1, 18'h00001, 2'b00); tick(); clr();
    set_a(2, 15'h001A, 1, 0, 18'h0, 2'b00);
    set_b(2, 15'h0018, 1, 0, 18'h0, 2'b00); tick(); clr();
    check("rd1_eff13", rd_a[2], 18'h1);
    check("rd1_eff12", rd_b[2], 18'h0);
    set_a(2, 15'h001C, 1, 0, 18'h0, 2'b00); tick(); clr();
    check("rd1_eff14", rd_a[2], 18'h0);

    // 1 mode: same-row writes to different bits both land
    set_a(2, 15'h0000, 0, 1, 18'h00001, 2'b00);
    set_b(2, 15'h0002, 0, 1, 18'h00001, 2'b00); tick(); clr();
`ifdef BRAM18_TDP_COLLISION_EN
    check("coll_nonoverlap", 18'(coll[2]), 18'h1);
`endif
    set_a(2, 15'h0000, 1, 0, 18'h0, 2'b00);
    set_b(2, 15'h0002, 1, 0, 18'h0, 2'b00); tick(); clr();
    check("ww_bit_a", rd_a[2], 18'h1);
    check("ww_bit_b", rd_b[2], 18'h1);

    // 18 mode: same-row write/write, A wins
    set_a(0, 15'h0040, 0, 1, 18'h11111, 2'b11);
    set_b(0, 15'h0040, 0, 1, 18'h22222, 2'b11); tick(); clr();
`ifdef BRAM18_TDP_COLLISION_EN
    check("coll_ww", 18'(coll[0]), 18'h1);
`endif
    set_a(0, 15'h0040, 1, 0, 18'h0, 2'b00); tick(); clr();
    check("ww_a_wins", rd_a[0], 18'h11111);
`ifdef BRAM18_TDP_COLLISION_EN
    check("coll_one_cycle", 18'(coll[0]), 18'h0);
`endif

    // read-first across ports and on the same port
    set_a(0, 15'h0040, 0, 1, 18'h33333, 2'b11);
    set_b(0, 15'h0040, 1, 0, 18'h0, 2'b00); tick(); clr();
    check("rf_cross", rd_b[0], 18'h11111);
`ifdef BRAM18_TDP_COLLISION_EN
    check("coll_rw", 18'(coll[0]), 18'h1);
`endif
    set_a(0, 15'h0040, 1, 1, 18'h04444, 2'b11); tick(); clr();
    check("rf_same_port", rd_a[0], 18'h33333);
    set_b(0, 15'h0040, 1, 0, 18'h0, 2'b00); tick(); clr();
    check("rf_after", rd_b[0], 18'h04444);

    // flush beats a pending read and leaves the array alone
    set_b(0, 15'h0040, 1, 0, 18'h0, 2'b00); flush[0] = 1; tick(); clr();
    check("flush_a", rd_a[0], 18'h0);
    check("flush_b", rd_b[0], 18'h0);
    set_a(0, 15'h0040, 1, 0, 18'h0, 2'b00); tick(); clr();
    check("post_flush_rd", rd_a[0], 18'h04444);

    // reset mid-read with a write attempt that must be ignored
    rst_n = 1'b0;
    set_a(0, 15'h0000, 1, 0, 18'h0, 2'b00);
    set_b(0, 15'h0040, 0, 1, 18'h3FFFF, 2'b11); tick(); clr();
    check("rst_rd_a", rd_a[0], 18'h0);
    rst_n = 1'b1;
    tick();
    check("rst_next_cycle", rd_a[0], 18'h0);
    set_a(0, 15'h0040, 1, 0, 18'h0, 2'b00);
    set_b(0, 15'h0000, 1, 0, 18'h0, 2'b00); tick(); clr();
    check("retain_row2", rd_a[0], 18'h04444);
    check("retain_row0", rd_b[0], 18'h100FF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
